// File: rtl/y86_alu_pkg.sv
// Shared constants and types for the Y86 execute-stage ALU: function codes,
// branch/cmov condition codes, and the architectural condition-code register layout.
package y86_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_LE     = 4'd1;
  localparam logic [3:0] COND_L      = 4'd2;
  localparam logic [3:0] COND_E      = 4'd3;
  localparam logic [3:0] COND_NE     = 4'd4;
  localparam logic [3:0] COND_GE     = 4'd5;
  localparam logic [3:0] COND_G      = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Signed comparisons use SF^OF as "less than"; codes 7..15 never fire.
  function automatic logic eval_cond(input cc_t cc, input logic [3:0] cond);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (cond)
      COND_ALWAYS: return 1'b1;
      COND_LE:     return lt | cc.zf;
      COND_L:      return lt;
      COND_E:      return cc.zf;
      COND_NE:     return !cc.zf;
      COND_GE:     return !lt;
      COND_G:      return !lt && !cc.zf;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu_core.sv
// Combinational Y86 OPq datapath: r = b OP a with zero/sign/overflow flags
// and an error flag for unsupported function codes.
module y86_alu_core
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             err
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = b + a;
  assign diff = b - a;

  // Operand order follows Y86: valB is the left-hand operand.
  always_comb begin
    r   = '0;
    of  = 1'b0;
    err = 1'b0;
    case (ifun)
      ALU_ADD: begin
        r  = sum;
        of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        r  = diff;
        of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: r = b & a;
      ALU_XOR: r = b ^ a;
      default: err = 1'b1;
    endcase
  end

  assign zf = (r == '0);
  assign sf = r[WIDTH-1];

endmodule

// File: rtl/y86_alu_pipe.sv
// Registered Y86 execute stage: one-deep result register with valid/ready
// backpressure, architectural CC register, and combinational cond evaluation.
module y86_alu_pipe
  import y86_alu_pkg::*;
#(
  parameter int   WIDTH    = 64,
  parameter logic RESET_ZF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             op_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  input  logic [3:0]       cond,
  output logic             cnd
);

  logic [WIDTH-1:0] core_r;
  logic             core_zf;
  logic             core_sf;
  logic             core_of;
  logic             core_err;
  logic             accept;
  cc_t              cc;

  y86_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .ifun (ifun),
    .a    (val_a),
    .b    (val_b),
    .r    (core_r),
    .zf   (core_zf),
    .sf   (core_sf),
    .of   (core_of),
    .err  (core_err)
  );

  // A slot is free when empty or when its current result leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      val_e     <= '0;
      op_err    <= 1'b0;
      cc        <= '{zf: RESET_ZF, sf: CC_RESET.sf, of: CC_RESET.of};
    end else begin
      if (accept) begin
        val_e     <= core_r;
        op_err    <= core_err;
        out_valid <= 1'b1;
        if (set_cc && !core_err) begin
          cc <= '{zf: core_zf, sf: core_sf, of: core_of};
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign cc_zf = cc.zf;
  assign cc_sf = cc.sf;
  assign cc_of = cc.of;

  always_comb begin
    cnd = eval_cond(cc, cond);
  end

endmodule

// File: tb/tb_y86_alu_pipe.sv
// Directed self-checking bench for y86_alu_pipe at WIDTH=64.
module tb_y86_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ifun;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        set_cc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] val_e;
  logic        op_err;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;
  logic [3:0]  cond;
  logic        cnd;

  int errors = 0;
  int checks = 0;

  y86_alu_pipe #(
    .WIDTH    (64),
    .RESET_ZF (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e     (val_e),
    .op_err    (op_err),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of),
    .cond      (cond),
    .cnd       (cnd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one request across a rising edge, then withdraws it 1ns later.
  task automatic drive(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic sc);
    in_valid = 1'b1;
    ifun     = f;
    val_a    = a;
    val_b    = b;
    set_cc   = sc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    set_cc   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    idle_cycle(); idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (val_e !== 64'd0) begin errors++; $display("[TB] FAIL reset_val_e: got %h expected 0", val_e); end
    checks++; if (op_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_op_err: got %b expected 0", op_err); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL reset_cc: got %b expected 100", {cc_zf, cc_sf, cc_of}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    cond = 4'd3; #1;
    checks++; if (cnd !== 1'b1) begin errors++; $display("[TB] FAIL reset_cnd_e: got %b expected 1", cnd); end
    cond = 4'd7; #1;
    checks++; if (cnd !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnd_7: got %b expected 0", cnd); end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_add();
    drive(4'd0, 64'd10, 64'd5, 1'b1);
    checks++; if (val_e !== 64'd15) begin errors++; $display("[TB] FAIL add_val_e: got %h expected 15", val_e); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_out_valid: got %b expected 1", out_valid); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin errors++; $display("[TB] FAIL add_cc: got %b expected 000", {cc_zf, cc_sf, cc_of}); end
    cond = 4'd4; #1;
    checks++; if (cnd !== 1'b1) begin errors++; $display("[TB] FAIL add_cnd_ne: got %b expected 1", cnd); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL consume_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_sub();
    drive(4'd1, 64'd64, -64'sd69, 1'b1);
    checks++; if (val_e !== 64'hFFFF_FFFF_FFFF_FF7B) begin errors++; $display("[TB] FAIL sub_val_e: got %h expected FFFFFFFFFFFFFF7B", val_e); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin errors++; $display("[TB] FAIL sub_cc: got %b expected 010", {cc_zf, cc_sf, cc_of}); end
    cond = 4'd2; #1;
    checks++; if (cnd !== 1'b1) begin errors++; $display("[TB] FAIL sub_cnd_l: got %b expected 1", cnd); end
    cond = 4'd6; #1;
    checks++; if (cnd !== 1'b0) begin errors++; $display("[TB] FAIL sub_cnd_g: got %b expected 0", cnd); end
    cond = 4'd1; #1;
    checks++; if (cnd !== 1'b1) begin errors++; $display("[TB] FAIL sub_cnd_le: got %b expected 1", cnd); end
    cond = 4'd5; #1;
    checks++; if (cnd !== 1'b0) begin errors++; $display("[TB] FAIL sub_cnd_ge: got %b expected 0", cnd); end
  endtask

  task automatic test_overflow();
    drive(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    checks++; if (val_e !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL ovf_add_val_e: got %h expected FFFFFFFFFFFFFFFE", val_e); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin errors++; $display("[TB] FAIL ovf_add_cc: got %b expected 011", {cc_zf, cc_sf, cc_of}); end
    cond = 4'd6; #1;
    checks++; if (cnd !== 1'b1) begin errors++; $display("[TB] FAIL ovf_cnd_g: got %b expected 1", cnd); end
    cond = 4'd2; #1;
    checks++; if (cnd !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cnd_l: got %b expected 0", cnd); end
    drive(4'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    checks++; if (val_e !== 64'd0) begin errors++; $display("[TB] FAIL min_sub_val_e: got %h expected 0", val_e); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL min_sub_cc: got %b expected 100", {cc_zf, cc_sf, cc_of}); end
    drive(4'd2, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    checks++; if (val_e !== 64'd0) begin errors++; $display("[TB] FAIL and_val_e: got %h expected 0", val_e); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL and_cc: got %b expected 100", {cc_zf, cc_sf, cc_of}); end
    drive(4'd0, 64'd1, 64'd1, 1'b0);
    checks++; if (val_e !== 64'd2) begin errors++; $display("[TB] FAIL nocc_val_e: got %h expected 2", val_e); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL nocc_cc: got %b expected 100", {cc_zf, cc_sf, cc_of}); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'd3, 64'hF0, 64'hFF, 1'b1);
    checks++; if (val_e !== 64'h0F) begin errors++; $display("[TB] FAIL bp_val_e: got %h expected 0F", val_e); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b1; ifun = 4'd1; val_a = 64'd5; val_b = 64'd5; set_cc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      checks++; if (val_e !== 64'h0F) begin errors++; $display("[TB] FAIL bp_stall_val_e[%0d]: got %h expected 0F", i, val_e); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall_out_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      checks++; if (cc_zf !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_cc_zf[%0d]: got %b expected 0", i, cc_zf); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    idle_cycle();
    in_valid = 1'b0; set_cc = 1'b0;
    checks++; if (val_e !== 64'd0) begin errors++; $display("[TB] FAIL bp_second_val_e: got %h expected 0", val_e); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_out_valid: got %b expected 1", out_valid); end
    checks++; if (cc_zf !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_cc_zf: got %b expected 1", cc_zf); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_invalid();
    drive(4'd1, 64'd64, -64'sd69, 1'b1);
    drive(4'd4, 64'd1, 64'd2, 1'b1);
    checks++; if (val_e !== 64'd0) begin errors++; $display("[TB] FAIL inv_val_e: got %h expected 0", val_e); end
    checks++; if (op_err !== 1'b1) begin errors++; $display("[TB] FAIL inv_op_err: got %b expected 1", op_err); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin errors++; $display("[TB] FAIL inv_cc: got %b expected 010", {cc_zf, cc_sf, cc_of}); end
    drive(4'd15, 64'd0, 64'd0, 1'b1);
    checks++; if (op_err !== 1'b1) begin errors++; $display("[TB] FAIL inv15_op_err: got %b expected 1", op_err); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin errors++; $display("[TB] FAIL inv15_cc: got %b expected 010", {cc_zf, cc_sf, cc_of}); end
    drive(4'd0, 64'd1, 64'd1, 1'b0);
    checks++; if (op_err !== 1'b0) begin errors++; $display("[TB] FAIL inv_clear_op_err: got %b expected 0", op_err); end
    checks++; if (val_e !== 64'd2) begin errors++; $display("[TB] FAIL inv_clear_val_e: got %h expected 2", val_e); end
  endtask

  task automatic test_back_to_back();
    drive(4'd0, 64'd100, 64'd200, 1'b0);
    checks++; if (val_e !== 64'd300) begin errors++; $display("[TB] FAIL b2b_0: got %h expected 12C", val_e); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
    drive(4'd1, 64'd1, 64'd0, 1'b0);
    checks++; if (val_e !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_1: got %h expected FFFFFFFFFFFFFFFF", val_e); end
    drive(4'd3, 64'h1234, 64'h1234, 1'b0);
    checks++; if (val_e !== 64'd0) begin errors++; $display("[TB] FAIL b2b_2: got %h expected 0", val_e); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out_valid: got %b expected 1", out_valid); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(4'd0, 64'd3, 64'd4, 1'b1);
    checks++; if (val_e !== 64'd7) begin errors++; $display("[TB] FAIL mid_val_e: got %h expected 7", val_e); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin errors++; $display("[TB] FAIL mid_cc: got %b expected 000", {cc_zf, cc_sf, cc_of}); end
    idle_cycle();
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; ifun = 4'd0; val_a = 64'd8; val_b = 64'd9; set_cc = 1'b1;
    idle_cycle();
    rst_n = 1'b0; in_valid = 1'b0; set_cc = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (val_e !== 64'd0) begin errors++; $display("[TB] FAIL mid_rst_val_e: got %h expected 0", val_e); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("[TB] FAIL mid_rst_cc: got %b expected 100", {cc_zf, cc_sf, cc_of}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    idle_cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ifun = 4'd0; val_a = '0; val_b = '0;
    set_cc = 1'b0; out_ready = 1'b1; cond = 4'd0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
